plab2_mem_latency_responder: RTL and testbench

Responder end of the processor memory request/response interface: accepts `VC_MEM_REQ_MSG(8,32,32)` requests and returns `VC_MEM_RESP_MSG(8,32)` responses in order after a fixed, parameterised latency. It sits behind a processor's imem or dmem port in the test harness, or behind a cache, as a word-organised single-port memory. Credit-based flow control bounds in-flight requests, so responses are never dropped under `memresp_rdy` backpressure.

---
 rtl/plab2_mem_latency_responder.sv | 178 +++++++++++++++++
 tb/tb_plab2_mem_latency_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plab2_mem_latency_responder.sv
// Word-organised memory responder: in-order responses p_latency cycles after request fire.
// Credit counter caps in-flight requests at p_num_entries; memresp_rdy low stalls memreq_rdy, never drops.
module plab2_fifo #(
    parameter int p_width = 45,
    parameter int p_depth = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_vld,
    input  logic [p_width-1:0] enq_dat,
    output logic               deq_vld,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_dat
);
    localparam int pw = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int cw = $clog2(p_depth + 1);
    localparam logic [pw-1:0] last_ptr = pw'(p_depth - 1);

    logic [p_width-1:0] buf_q [p_depth];
    logic [pw-1:0]      wr_ptr;
    logic [pw-1:0]      rd_ptr;
    logic [cw-1:0]      cnt;
    logic               deq_fire;

    assign deq_vld  = (cnt != '0);
    assign deq_dat  = buf_q[rd_ptr];
    assign deq_fire = deq_vld && deq_rdy;

    // No full check: the upstream credit counter guarantees space.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq_vld)
                wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + pw'(1);
            if (deq_fire)
                rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + pw'(1);
            if (enq_vld && !deq_fire)
                cnt <= cnt + cw'(1);
            else if (!enq_vld && deq_fire)
                cnt <= cnt - cw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_vld)
            buf_q[wr_ptr] <= enq_dat;
    end
endmodule

module plab2_mem_latency_responder #(
    parameter int p_mem_nbytes  = 65536,
    parameter int p_latency     = 1,
    parameter int p_num_entries = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [76:0] memreq_msg,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    output logic [44:0] memresp_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy
);
    localparam int aw     = $clog2(p_mem_nbytes);
    localparam int nwords = p_mem_nbytes / 4;
    localparam int cw     = $clog2(p_num_entries + 1);
    localparam logic [cw-1:0] max_cnt = cw'(p_num_entries);

    logic [31:0]   mem [nwords];
    logic [2:0]    req_type;
    logic [7:0]    req_opq;
    logic [1:0]    req_len;
    logic [31:0]   req_data;
    logic [aw-3:0] word_idx;
    logic [1:0]    byte_off;
    logic [2:0]    nbytes;
    logic [31:0]   rd_word;
    logic [31:0]   rd_data;
    logic [31:0]   wr_word;
    logic [44:0]   resp_dat;
    logic          req_fire;
    logic          resp_fire;
    logic          is_write;
    logic [cw-1:0] count;
    logic          enq_vld;
    logic [44:0]   enq_dat;
    logic          fifo_vld;
    logic          unused_addr_hi;

    assign req_type       = memreq_msg[76:74];
    assign req_opq        = memreq_msg[73:66];
    assign byte_off       = memreq_msg[35:34];
    assign word_idx       = memreq_msg[34+aw-1:36];
    assign unused_addr_hi = ^memreq_msg[65:34+aw];
    assign req_len        = memreq_msg[33:32];
    assign req_data       = memreq_msg[31:0];
    assign nbytes         = (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};
    assign is_write       = (req_type == 3'd1);
    assign rd_word        = mem[word_idx];

    assign memreq_rdy  = !reset && (count < max_cnt);
    assign req_fire    = memreq_val && memreq_rdy;
    assign memresp_val = fifo_vld && !reset;
    assign resp_fire   = memresp_val && memresp_rdy;

    // Lanes past byte 3 are dropped on write and read back as zero.
    always_comb begin
        rd_data = '0;
        wr_word = rd_word;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(nbytes) && (int'(byte_off) + k) < 4) begin
                rd_data[8*k +: 8]                      = rd_word[8*(int'(byte_off)+k) +: 8];
                wr_word[8*(int'(byte_off)+k) +: 8]     = req_data[8*k +: 8];
            end
        end
    end

    assign resp_dat = {req_type, req_opq, req_len, is_write ? 32'd0 : rd_data};

    always_ff @(posedge clk) begin
        if (req_fire && is_write)
            mem[word_idx] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (req_fire && !resp_fire)
            count <= count + cw'(1);
        else if (!req_fire && resp_fire)
            count <= count - cw'(1);
    end

    generate
        if (p_latency == 1) begin : g_no_delay
            assign enq_vld = req_fire;
            assign enq_dat = resp_dat;
        end else begin : g_delay
            logic [p_latency-2:0] dl_vld;
            logic [44:0]          dl_dat [p_latency-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    dl_vld <= '0;
                end else begin
                    dl_vld[0] <= req_fire;
                    for (int i = 1; i < p_latency - 1; i++)
                        dl_vld[i] <= dl_vld[i-1];
                end
            end

            always_ff @(posedge clk) begin
                dl_dat[0] <= resp_dat;
                for (int i = 1; i < p_latency - 1; i++)
                    dl_dat[i] <= dl_dat[i-1];
            end

            assign enq_vld = dl_vld[p_latency-2];
            assign enq_dat = dl_dat[p_latency-2];
        end
    endgenerate

    plab2_fifo #(
        .p_width (45),
        .p_depth (p_num_entries)
    ) u_resp_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq_vld (enq_vld),
        .enq_dat (enq_dat),
        .deq_vld (fifo_vld),
        .deq_rdy (memresp_rdy),
        .deq_dat (memresp_msg)
    );
endmodule

// File: tb/tb_plab2_mem_latency_responder.sv
// Directed bench: default, latency-3 and 256-byte instances share clock, reset and request bus.
module tb_plab2_mem_latency_responder;
    logic             clk = 1'b0;
    logic             reset;
    logic [76:0]      memreq_msg;
    logic [2:0]       req_val;
    logic [2:0]       req_rdy;
    logic [2:0]       resp_val;
    logic [2:0][44:0] resp_msg;
    logic             memresp_rdy;
    int               vectors = 0;
    int               miscompares = 0;

    always #5 clk = ~clk;

    plab2_mem_latency_responder u_dut (
        .clk(clk), .reset(reset), .memreq_msg(memreq_msg), .memreq_val(req_val[0]),
        .memreq_rdy(req_rdy[0]), .memresp_msg(resp_msg[0]), .memresp_val(resp_val[0]),
        .memresp_rdy(memresp_rdy)
    );

    plab2_mem_latency_responder #(.p_latency(3), .p_num_entries(4)) u_lat (
        .clk(clk), .reset(reset), .memreq_msg(memreq_msg), .memreq_val(req_val[1]),
        .memreq_rdy(req_rdy[1]), .memresp_msg(resp_msg[1]), .memresp_val(resp_val[1]),
        .memresp_rdy(memresp_rdy)
    );

    plab2_mem_latency_responder #(.p_mem_nbytes(256)) u_wrap (
        .clk(clk), .reset(reset), .memreq_msg(memreq_msg), .memreq_val(req_val[2]),
        .memreq_rdy(req_rdy[2]), .memresp_msg(resp_msg[2]), .memresp_val(resp_val[2]),
        .memresp_rdy(memresp_rdy)
    );

    function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [1:0] l,
                                           input logic [31:0] d);
        return {t, o, a, l, d};
    endfunction

    function automatic logic [44:0] mk_resp(input logic [2:0] t, input logic [7:0] o,
                                            input logic [1:0] l, input logic [31:0] d);
        return {t, o, l, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_val = 3'b000;
        memresp_rdy = 1'b1;
        memreq_msg = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (req_rdy !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_req_rdy: got %b, expected 000", req_rdy);
        end
        vectors++;
        if (resp_val !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_resp_val: got %b, expected 000", resp_val);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (req_rdy !== 3'b111 || resp_val !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset: rdy %b val %b, expected rdy 111 val 000", req_rdy, resp_val);
        end
        tick();
    endtask

    task automatic test_write_read;
        memresp_rdy = 1'b1;
        memreq_msg = mk_req(3'd1, 8'h11, 32'h100, 2'd0, 32'hDEADBEEF);
        req_val[0] = 1'b1;
        vectors++;
        if (req_rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_req_rdy: got %b, expected 1", req_rdy[0]);
        end
        tick();
        memreq_msg = mk_req(3'd0, 8'h22, 32'h100, 2'd0, 32'h0);
        vectors++;
        if (resp_val[0] !== 1'b1 || resp_msg[0] !== mk_resp(3'd1, 8'h11, 2'd0, 32'h0)) begin
            miscompares++;
            $display("FAIL write_resp: val %b msg %h, expected val 1 msg %h",
                     resp_val[0], resp_msg[0], mk_resp(3'd1, 8'h11, 2'd0, 32'h0));
        end
        tick();
        req_val[0] = 1'b0;
        vectors++;
        if (resp_val[0] !== 1'b1 || resp_msg[0] !== mk_resp(3'd0, 8'h22, 2'd0, 32'hDEADBEEF)) begin
            miscompares++;
            $display("FAIL read_resp: val %b msg %h, expected val 1 msg %h",
                     resp_val[0], resp_msg[0], mk_resp(3'd0, 8'h22, 2'd0, 32'hDEADBEEF));
        end
        tick();
        vectors++;
        if (resp_val[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_idle: val %b, expected 0", resp_val[0]);
        end
    endtask

    task automatic test_subword;
        logic [76:0] reqs [10];
        logic [44:0] exps [10];
        reqs[0] = mk_req(3'd1, 8'h01, 32'h100, 2'd0, 32'h11223344); exps[0] = mk_resp(3'd1, 8'h01, 2'd0, 32'h0);
        reqs[1] = mk_req(3'd1, 8'h02, 32'h104, 2'd0, 32'h55667788); exps[1] = mk_resp(3'd1, 8'h02, 2'd0, 32'h0);
        reqs[2] = mk_req(3'd1, 8'h03, 32'h102, 2'd1, 32'h000000AB); exps[2] = mk_resp(3'd1, 8'h03, 2'd1, 32'h0);
        reqs[3] = mk_req(3'd0, 8'h04, 32'h100, 2'd0, 32'h0);        exps[3] = mk_resp(3'd0, 8'h04, 2'd0, 32'h11AB3344);
        reqs[4] = mk_req(3'd0, 8'h05, 32'h101, 2'd2, 32'h0);        exps[4] = mk_resp(3'd0, 8'h05, 2'd2, 32'h0000AB33);
        reqs[5] = mk_req(3'd0, 8'h06, 32'h103, 2'd2, 32'h0);        exps[5] = mk_resp(3'd0, 8'h06, 2'd2, 32'h00000011);
        reqs[6] = mk_req(3'd1, 8'h07, 32'h103, 2'd2, 32'h0000CCDD); exps[6] = mk_resp(3'd1, 8'h07, 2'd2, 32'h0);
        reqs[7] = mk_req(3'd0, 8'h08, 32'h100, 2'd0, 32'h0);        exps[7] = mk_resp(3'd0, 8'h08, 2'd0, 32'hDDAB3344);
        reqs[8] = mk_req(3'd0, 8'h09, 32'h104, 2'd0, 32'h0);        exps[8] = mk_resp(3'd0, 8'h09, 2'd0, 32'h55667788);
        reqs[9] = mk_req(3'd0, 8'h0A, 32'h102, 2'd3, 32'h0);        exps[9] = mk_resp(3'd0, 8'h0A, 2'd3, 32'h0000DDAB);
        memresp_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            memreq_msg = reqs[i];
            req_val[0] = 1'b1;
            vectors++;
            if (req_rdy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL subword_rdy[%0d]: got %b, expected 1", i, req_rdy[0]);
            end
            tick();
            vectors++;
            if (resp_val[0] !== 1'b1 || resp_msg[0] !== exps[i]) begin
                miscompares++;
                $display("FAIL subword_resp[%0d]: val %b msg %h, expected val 1 msg %h",
                         i, resp_val[0], resp_msg[0], exps[i]);
            end
        end
        req_val[0] = 1'b0;
        tick();
    endtask

    task automatic test_backpressure;
        logic [44:0] exps [4];
        for (int i = 0; i < 4; i++)
            exps[i] = mk_resp(3'd0, 8'h30 + 8'(i), 2'd0, 32'h55667788);
        memresp_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            memreq_msg = mk_req(3'd0, 8'h30 + 8'(i), 32'h104, 2'd0, 32'h0);
            req_val[0] = 1'b1;
            vectors++;
            if (req_rdy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_accept[%0d]: rdy %b, expected 1", i, req_rdy[0]);
            end
            tick();
        end
        memreq_msg = mk_req(3'd0, 8'h32, 32'h104, 2'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (req_rdy[0] !== 1'b0 || resp_val[0] !== 1'b1 || resp_msg[0] !== exps[0]) begin
                miscompares++;
                $display("FAIL bp_stall[%0d]: rdy %b val %b msg %h, expected rdy 0 val 1 msg %h",
                         c, req_rdy[0], resp_val[0], resp_msg[0], exps[0]);
            end
            tick();
        end
        memresp_rdy = 1'b1;
        vectors++;
        if (req_rdy[0] !== 1'b0 || resp_msg[0] !== exps[0]) begin
            miscompares++;
            $display("FAIL bp_same_cycle: rdy %b msg %h, expected rdy 0 msg %h", req_rdy[0], resp_msg[0], exps[0]);
        end
        tick();
        vectors++;
        if (req_rdy[0] !== 1'b1 || resp_val[0] !== 1'b1 || resp_msg[0] !== exps[1]) begin
            miscompares++;
            $display("FAIL bp_reassert: rdy %b val %b msg %h, expected rdy 1 val 1 msg %h",
                     req_rdy[0], resp_val[0], resp_msg[0], exps[1]);
        end
        tick();
        memreq_msg = mk_req(3'd0, 8'h33, 32'h104, 2'd0, 32'h0);
        vectors++;
        if (req_rdy[0] !== 1'b1 || resp_val[0] !== 1'b1 || resp_msg[0] !== exps[2]) begin
            miscompares++;
            $display("FAIL bp_resp2: rdy %b val %b msg %h, expected rdy 1 val 1 msg %h",
                     req_rdy[0], resp_val[0], resp_msg[0], exps[2]);
        end
        tick();
        req_val[0] = 1'b0;
        vectors++;
        if (resp_val[0] !== 1'b1 || resp_msg[0] !== exps[3]) begin
            miscompares++;
            $display("FAIL bp_resp3: val %b msg %h, expected val 1 msg %h", resp_val[0], resp_msg[0], exps[3]);
        end
        tick();
        vectors++;
        if (resp_val[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: val %b, expected 0", resp_val[0]);
        end
    endtask

    task automatic test_latency;
        logic [76:0] reqs [16];
        logic [44:0] exps [16];
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            d = 32'(i + 1) * 32'h01010101;
            reqs[i]   = mk_req(3'd1, 8'(i), 32'(4 * i), 2'd0, d);
            exps[i]   = mk_resp(3'd1, 8'(i), 2'd0, 32'h0);
            reqs[i+8] = mk_req(3'd0, 8'h80 + 8'(i), 32'(4 * i), 2'd0, 32'h0);
            exps[i+8] = mk_resp(3'd0, 8'h80 + 8'(i), 2'd0, d);
        end
        memresp_rdy = 1'b1;
        for (int k = 0; k < 19; k++) begin
            if (k < 16) begin
                memreq_msg = reqs[k];
                req_val[1] = 1'b1;
                vectors++;
                if (req_rdy[1] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lat_stall[%0d]: rdy %b, expected 1", k, req_rdy[1]);
                end
            end else begin
                req_val[1] = 1'b0;
            end
            vectors++;
            if (k < 3) begin
                if (resp_val[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lat_early[%0d]: val %b, expected 0", k, resp_val[1]);
                end
            end else if (resp_val[1] !== 1'b1 || resp_msg[1] !== exps[k-3]) begin
                miscompares++;
                $display("FAIL lat_resp[%0d]: val %b msg %h, expected val 1 msg %h",
                         k - 3, resp_val[1], resp_msg[1], exps[k-3]);
            end
            tick();
        end
        vectors++;
        if (resp_val[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_drain: val %b, expected 0", resp_val[1]);
        end
    endtask

    task automatic test_wrap;
        logic [76:0] reqs [3];
        logic [44:0] exps [3];
        reqs[0] = mk_req(3'd1, 8'h61, 32'h1004, 2'd0, 32'h5A5A5A5A);     exps[0] = mk_resp(3'd1, 8'h61, 2'd0, 32'h0);
        reqs[1] = mk_req(3'd0, 8'h62, 32'h0004, 2'd0, 32'h0);            exps[1] = mk_resp(3'd0, 8'h62, 2'd0, 32'h5A5A5A5A);
        reqs[2] = mk_req(3'd0, 8'h63, 32'hFFFF_FF04, 2'd0, 32'h0);       exps[2] = mk_resp(3'd0, 8'h63, 2'd0, 32'h5A5A5A5A);
        memresp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            memreq_msg = reqs[i];
            req_val[2] = 1'b1;
            tick();
            vectors++;
            if (resp_val[2] !== 1'b1 || resp_msg[2] !== exps[i]) begin
                miscompares++;
                $display("FAIL wrap_resp[%0d]: val %b msg %h, expected val 1 msg %h",
                         i, resp_val[2], resp_msg[2], exps[i]);
            end
        end
        req_val[2] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        memresp_rdy = 1'b1;
        memreq_msg = mk_req(3'd1, 8'h70, 32'h108, 2'd0, 32'hCAFEF00D);
        req_val[0] = 1'b1;
        tick();
        req_val[0] = 1'b0;
        tick();
        memresp_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            memreq_msg = mk_req(3'd0, 8'h40 + 8'(i), 32'h108, 2'd0, 32'h0);
            req_val[0] = 1'b1;
            tick();
        end
        req_val[0] = 1'b0;
        vectors++;
        if (resp_val[0] !== 1'b1 || req_rdy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_pending: val %b rdy %b, expected val 1 rdy 0", resp_val[0], req_rdy[0]);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (resp_val[0] !== 1'b0 || req_rdy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_in_reset: val %b rdy %b, expected val 0 rdy 0", resp_val[0], req_rdy[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (resp_val[0] !== 1'b0 || req_rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_after_reset: val %b rdy %b, expected val 0 rdy 1", resp_val[0], req_rdy[0]);
        end
        for (int i = 0; i < 2; i++) begin
            memreq_msg = mk_req(3'd0, 8'h50 + 8'(i), 32'h108, 2'd0, 32'h0);
            req_val[0] = 1'b1;
            vectors++;
            if (req_rdy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_credit[%0d]: rdy %b, expected 1", i, req_rdy[0]);
            end
            tick();
        end
        req_val[0] = 1'b0;
        vectors++;
        if (req_rdy[0] !== 1'b0 || resp_val[0] !== 1'b1 ||
            resp_msg[0] !== mk_resp(3'd0, 8'h50, 2'd0, 32'hCAFEF00D)) begin
            miscompares++;
            $display("FAIL mid_first: rdy %b val %b msg %h, expected rdy 0 val 1 msg %h", req_rdy[0],
                     resp_val[0], resp_msg[0], mk_resp(3'd0, 8'h50, 2'd0, 32'hCAFEF00D));
        end
        memresp_rdy = 1'b1;
        tick();
        vectors++;
        if (resp_val[0] !== 1'b1 || resp_msg[0] !== mk_resp(3'd0, 8'h51, 2'd0, 32'hCAFEF00D)) begin
            miscompares++;
            $display("FAIL mid_second: val %b msg %h, expected val 1 msg %h",
                     resp_val[0], resp_msg[0], mk_resp(3'd0, 8'h51, 2'd0, 32'hCAFEF00D));
        end
        tick();
        vectors++;
        if (resp_val[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_no_stale: val %b, expected 0", resp_val[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_subword();
        test_backpressure();
        test_latency();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
